// File: rtl/wisc_pkg.sv
// Shared types and constants for the WISC pipeline memory stage.
package wisc_pkg;

    localparam int DATA_W_DEFAULT = 16;

    // Stack pointer register number (R15)
    localparam logic [3:0] SP_REG = 4'hF;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

endpackage

// File: rtl/mem_unit.sv
// Memory stage of the 16-bit WISC pipeline: loads/stores over a handshaked
// data memory, call push / ret pop on R15, registered write-back payload.
module mem_unit
    import wisc_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              RegWrite_in,
    input  logic              mem_to_reg_in,
    input  logic              reg_to_mem_in,
    input  logic              call_in,
    input  logic              ret_future_in,
    input  logic [3:0]        reg_rd_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] sw_data,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_re,
    output logic              dmem_we,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              mem_stall,
    output logic              wb_valid,
    output logic              RegWrite_out,
    output logic [3:0]        reg_rd_out,
    output logic [DATA_W-1:0] wb_data,
    output logic              ret_wb,
    output logic [DATA_W-1:0] PC_stack_pointer,
    output logic              mem_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t       state;
    logic [CNT_W-1:0] wait_cnt;

    // Attributes of the outstanding memory op, latched on acceptance
    logic             op_store;
    logic             op_call;
    logic             op_ret;
    logic             op_regwrite;
    logic [3:0]       op_rd;

    logic             memop;
    logic             abort;

    // Decode the incoming op and detect the wait-limit expiry
    always_comb begin
        memop = ex_valid & (mem_to_reg_in | reg_to_mem_in);
        abort = (state == WAIT) & ~dmem_ready & (wait_cnt == CNT_LAST);
    end

    // Upstream holds while a memory op is being accepted or is still pending
    always_comb begin
        mem_stall = ((state == IDLE) & memop) |
                    ((state == WAIT) & ~dmem_ready & ~abort);
    end

    // Access FSM, memory request registers and write-back payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            op_store         <= 1'b0;
            op_call          <= 1'b0;
            op_ret           <= 1'b0;
            op_regwrite      <= 1'b0;
            op_rd            <= '0;
            dmem_addr        <= '0;
            dmem_wdata       <= '0;
            dmem_re          <= 1'b0;
            dmem_we          <= 1'b0;
            wb_valid         <= 1'b0;
            RegWrite_out     <= 1'b0;
            reg_rd_out       <= '0;
            wb_data          <= '0;
            ret_wb           <= 1'b0;
            PC_stack_pointer <= '0;
            mem_err          <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            ret_wb   <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (memop) begin
                        // A set store flag overrides a simultaneous load flag,
                        // so call only qualifies stores and ret only loads.
                        state       <= WAIT;
                        wait_cnt    <= '0;
                        dmem_addr   <= alu_result;
                        dmem_wdata  <= sw_data;
                        dmem_we     <= reg_to_mem_in;
                        dmem_re     <= ~reg_to_mem_in;
                        op_store    <= reg_to_mem_in;
                        op_call     <= reg_to_mem_in & call_in;
                        op_ret      <= ~reg_to_mem_in & ret_future_in;
                        op_regwrite <= RegWrite_in;
                        op_rd       <= reg_rd_in;
                    end else if (ex_valid) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= alu_result;
                        RegWrite_out <= RegWrite_in;
                        reg_rd_out   <= reg_rd_in;
                    end
                end
                WAIT: begin
                    if (dmem_ready) begin
                        state    <= IDLE;
                        dmem_re  <= 1'b0;
                        dmem_we  <= 1'b0;
                        wb_valid <= 1'b1;
                        if (op_call) begin
                            wb_data      <= dmem_addr;
                            reg_rd_out   <= SP_REG;
                            RegWrite_out <= 1'b1;
                        end else if (op_ret) begin
                            PC_stack_pointer <= dmem_rdata;
                            ret_wb           <= 1'b1;
                            wb_data          <= dmem_addr + DATA_W'(1);
                            reg_rd_out       <= SP_REG;
                            RegWrite_out     <= 1'b1;
                        end else if (op_store) begin
                            wb_data      <= dmem_addr;
                            reg_rd_out   <= op_rd;
                            RegWrite_out <= op_regwrite;
                        end else begin
                            wb_data      <= dmem_rdata;
                            reg_rd_out   <= op_rd;
                            RegWrite_out <= op_regwrite;
                        end
                    end else if (abort) begin
                        state        <= IDLE;
                        dmem_re      <= 1'b0;
                        dmem_we      <= 1'b0;
                        wb_valid     <= 1'b1;
                        mem_err      <= 1'b1;
                        RegWrite_out <= 1'b0;
                        reg_rd_out   <= op_rd;
                        wb_data      <= dmem_addr;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_unit.sv
// Scoreboard bench for mem_unit: driver pushes expected write-backs computed
// from an array memory model, a monitor pops and compares on wb_valid, and a
// memory responder serves requests with per-op latencies.
module tb_mem_unit;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, RegWrite_in, mem_to_reg_in, reg_to_mem_in;
    logic        call_in, ret_future_in;
    logic [3:0]  reg_rd_in;
    logic [15:0] alu_result, sw_data;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_re, dmem_we, dmem_ready;
    logic        mem_stall, wb_valid, RegWrite_out, ret_wb, mem_err;
    logic [3:0]  reg_rd_out;
    logic [15:0] wb_data, PC_stack_pointer;

    mem_unit #(.DATA_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .RegWrite_in(RegWrite_in),
        .mem_to_reg_in(mem_to_reg_in), .reg_to_mem_in(reg_to_mem_in),
        .call_in(call_in), .ret_future_in(ret_future_in), .reg_rd_in(reg_rd_in),
        .alu_result(alu_result), .sw_data(sw_data), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_re(dmem_re), .dmem_we(dmem_we),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .mem_stall(mem_stall),
        .wb_valid(wb_valid), .RegWrite_out(RegWrite_out), .reg_rd_out(reg_rd_out),
        .wb_data(wb_data), .ret_wb(ret_wb), .PC_stack_pointer(PC_stack_pointer),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit valid, rw, ld, st, call, ret;
        logic [3:0]  rd;
        logic [15:0] alu, sw;
    } op_t;

    typedef struct {
        bit rw, chk_rd, chk_data, ret, err;
        logic [3:0]  rd;
        logic [15:0] data, pc;
        int cyc;
    } exp_t;

    typedef struct {
        bit wr;
        logic [15:0] addr, wdata;
        int lat;   // 0 = never ready
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];

    logic [15:0] mem     [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a ^ 16'hA5C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic drive(input op_t o);
        ex_valid      = o.valid;
        RegWrite_in   = o.rw;
        mem_to_reg_in = o.ld;
        reg_to_mem_in = o.st;
        call_in       = o.call;
        ret_future_in = o.ret;
        reg_rd_in     = o.rd;
        alu_result    = o.alu;
        sw_data       = o.sw;
    endtask

    task automatic scramble();
        ex_valid      = 1'($urandom);
        RegWrite_in   = 1'($urandom);
        mem_to_reg_in = 1'($urandom);
        reg_to_mem_in = 1'($urandom);
        call_in       = 1'($urandom);
        ret_future_in = 1'($urandom);
        reg_rd_in     = 4'($urandom);
        alu_result    = 16'($urandom);
        sw_data       = 16'($urandom);
    endtask

    // Reference write-back for a consumed op, from the ISA-level rules
    function automatic exp_t model(input op_t o, input int lat);
        exp_t e;
        e = '{default: '0};
        if (!(o.ld || o.st)) begin
            e.rw = o.rw; e.rd = o.rd; e.data = o.alu; e.chk_rd = 1; e.chk_data = 1;
        end else if (lat == 0) begin
            e.rw = 0; e.err = 1;
        end else if (o.st) begin
            ref_mem[o.alu] = o.sw;
            if (o.call) begin
                e.rw = 1; e.rd = 4'hF; e.data = o.alu; e.chk_rd = 1; e.chk_data = 1;
            end else begin
                e.rw = o.rw; e.rd = o.rd; e.chk_rd = 1;
            end
        end else if (o.ret) begin
            e.rw = 1; e.rd = 4'hF; e.data = o.alu + 16'd1; e.chk_rd = 1; e.chk_data = 1;
            e.ret = 1; e.pc = ref_rd(o.alu);
        end else begin
            e.rw = o.rw; e.rd = o.rd; e.data = ref_rd(o.alu); e.chk_rd = 1; e.chk_data = 1;
        end
        return e;
    endfunction

    task automatic issue(input op_t o, input int lat);
        bit   memop;
        int   waited;
        exp_t e;
        req_t r;
        @(negedge clk);
        drive(o);
        memop = o.valid && (o.ld || o.st);
        if (memop) begin
            r.wr = o.st; r.addr = o.alu; r.wdata = o.sw; r.lat = lat;
            req_q.push_back(r);
        end
        #4;
        chk("stall_first", {31'd0, mem_stall}, {31'd0, memop});
        if (!o.valid) return;
        waited = 0;
        while (mem_stall && waited <= TO + 3) begin
            @(negedge clk);
            scramble();
            #4;
            waited++;
        end
        if (mem_stall) begin
            chk("stall_stuck", 32'd1, 32'd0);
            return;
        end
        if (memop) chk("stall_cycles", waited, (lat == 0) ? TO : lat);
        e = model(o, lat);
        e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    function automatic op_t mk(input bit ld, input bit st, input bit call, input bit ret,
                               input bit rw, input logic [3:0] rd,
                               input logic [15:0] alu, input logic [15:0] sw);
        op_t o;
        o.valid = 1; o.ld = ld; o.st = st; o.call = call; o.ret = ret;
        o.rw = rw; o.rd = rd; o.alu = alu; o.sw = sw;
        return o;
    endfunction

    task automatic rand_op(output op_t o, output int lat);
        int kind, a;
        kind = $urandom_range(0, 9);
        a = $urandom_range(0, 15);
        o = mk(0, 0, 0, 0, 1'($urandom), 4'($urandom),
               (a < 8) ? 16'(a) : 16'hFFF0 + 16'(a), 16'($urandom));
        case (kind)
            0: begin o.valid = 0; o.ld = 1'($urandom); o.st = 1'($urandom); end
            1, 2: o.alu = 16'($urandom);
            3, 4: o.ld = 1;
            5: o.st = 1;
            6: begin o.st = 1; o.call = 1; end
            7: begin o.ld = 1; o.ret = 1; end
            default: begin o.ld = 1; o.st = 1; o.ret = 1'($urandom); end
        endcase
        lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
    endtask

    // Memory responder
    initial begin
        bit   active;
        bit   stable;
        int   held;
        req_t cur;
        active = 0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            dmem_ready = 1'b0;
            if (rst) begin
                active = 0;
                continue;
            end
            if (!active) begin
                if (dmem_re || dmem_we) begin
                    if (req_q.size() == 0) begin
                        chk("req_unexpected", 32'd1, 32'd0);
                    end else begin
                        cur = req_q.pop_front();
                        active = 1; held = 0; stable = 1;
                        chk("req_kind", {30'd0, dmem_we, dmem_re}, {30'd0, cur.wr, !cur.wr});
                        chk("req_addr", {16'd0, dmem_addr}, {16'd0, cur.addr});
                        if (cur.wr) chk("req_wdata", {16'd0, dmem_wdata}, {16'd0, cur.wdata});
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = 16'($urandom);
                end
            end
            if (active) begin
                if (dmem_re || dmem_we) begin
                    held++;
                    if (dmem_addr !== cur.addr || dmem_we !== cur.wr || dmem_re !== !cur.wr)
                        stable = 0;
                    if (cur.lat != 0 && held == cur.lat) begin
                        dmem_ready = 1'b1;
                        if (cur.wr) mem[cur.addr] = dmem_wdata;
                        else dmem_rdata = mem_rd(cur.addr);
                    end
                end else begin
                    chk("req_held", held, (cur.lat == 0) ? TO : cur.lat);
                    chk("req_stable", {31'd0, stable}, 32'd1);
                    active = 0;
                end
            end
        end
    end

    // Write-back monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) continue;
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_cycle", cyc, e.cyc);
                    chk("wb_regwrite", {31'd0, RegWrite_out}, {31'd0, e.rw});
                    chk("wb_ret", {31'd0, ret_wb}, {31'd0, e.ret});
                    chk("wb_err", {31'd0, mem_err}, {31'd0, e.err});
                    if (e.chk_rd) chk("wb_rd", {28'd0, reg_rd_out}, {28'd0, e.rd});
                    if (e.chk_data) chk("wb_data", {16'd0, wb_data}, {16'd0, e.data});
                    if (e.ret) chk("wb_pc", {16'd0, PC_stack_pointer}, {16'd0, e.pc});
                end
            end else if (ret_wb || mem_err) begin
                chk("pulse_without_wb", {30'd0, ret_wb, mem_err}, 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        op_t o;
        int  lat;
        int  wait_n;
        o = '{default: '0};
        drive(o);
        rst = 1'b1;
        mem[16'h0040] = 16'hBEEF;
        ref_mem[16'h0040] = 16'hBEEF;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_bus", {dmem_addr, dmem_wdata}, 32'd0);
        chk("rst_wb", {wb_data, PC_stack_pointer}, 32'd0);
        chk("rst_ctl", {24'd0, dmem_re, dmem_we, wb_valid, RegWrite_out, ret_wb, mem_err, mem_stall, 1'b0},
            32'd0);
        chk("rst_rd", {28'd0, reg_rd_out}, 32'd0);
        rst = 1'b0;

        issue(mk(0, 0, 0, 0, 1, 4'd3, 16'h1234, 16'h0000), 1);
        issue(mk(1, 0, 0, 0, 1, 4'd5, 16'h0040, 16'h0000), 3);
        issue(mk(0, 1, 1, 0, 0, 4'd2, 16'hFFFE, 16'h0102), 2);
        issue(mk(1, 0, 0, 1, 0, 4'd7, 16'hFFFE, 16'h0000), 1);
        issue(mk(0, 1, 0, 0, 1, 4'd6, 16'h0008, 16'h5555), 0);
        issue(mk(1, 0, 0, 1, 0, 4'd1, 16'hFFFF, 16'h0000), 2);
        issue(mk(1, 1, 0, 1, 1, 4'd4, 16'h0003, 16'h7777), 1);
        issue(mk(1, 0, 0, 0, 1, 4'd9, 16'h0003, 16'h0000), 1);

        // Reset while a load is waiting on memory
        @(negedge clk);
        o = mk(1, 0, 0, 0, 1, 4'd8, 16'h0010, 16'h0000);
        drive(o);
        req_q.push_back('{wr: 1'b0, addr: 16'h0010, wdata: 16'h0000, lat: 0});
        repeat (3) @(negedge clk);
        #2;
        chk("pre_rst_re", {31'd0, dmem_re}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_re", {30'd0, dmem_re, wb_valid}, 32'd0);
        ex_valid = 1'b0;
        #1;
        chk("rst_async_stall", {31'd0, mem_stall}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        issue(mk(0, 0, 0, 0, 1, 4'd11, 16'hCAFE, 16'h0000), 1);

        for (int i = 0; i < 300; i++) begin
            rand_op(o, lat);
            issue(o, lat);
        end

        @(negedge clk);
        o = '{default: '0};
        drive(o);
        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        repeat (2) @(negedge clk);
        chk("drain_wb", exp_q.size(), 0);
        chk("drain_req", req_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
